// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter. It picks ALU or load writeback round-robin,
// registers the write port, and keeps a pending-write scoreboard for decode.
module regfile_wb_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  output logic        wr_en,
  output logic [4:0]  wr_sel,
  output logic [31:0] wr_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        issue_stall,
  input  logic [4:0]  rs1_sel,
  input  logic [4:0]  rs2_sel,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic [31:0] busy_vec
);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;

  wb_req_t     a_req, b_req, win_req;
  logic        last_grant_b;
  logic        xfer;
  logic        issue_ok;
  logic [31:1] busy_q;

  assign a_req = {a_rd, a_data};
  assign b_req = {b_rd, b_data};

  // Each ready looks only at both valids and the last winner, never at the other ready.
  always_comb begin
    a_ready = a_valid && (!b_valid || last_grant_b);
    b_ready = b_valid && (!a_valid || !last_grant_b);
  end

  assign xfer    = a_ready || b_ready;
  assign win_req = a_ready ? a_req : b_req;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)     last_grant_b <= 1'b1;
    else if (xfer) last_grant_b <= b_ready;
  end

  // An x0 write is accepted upstream but never reaches the file.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_sel  <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= xfer && (win_req.rd != 5'd0);
      if (xfer) begin
        wr_sel  <= win_req.rd;
        wr_data <= win_req.data;
      end
    end
  end

  assign issue_stall = issue_valid && (issue_rd != 5'd0) && busy_vec[issue_rd];
  assign issue_ok    = issue_valid && !issue_stall && (issue_rd != 5'd0);

  // Per-register pending bit; a new issue beats a retiring write on the same edge.
  for (genvar i = 1; i < 32; i++) begin : g_busy
    always_ff @(posedge clock or posedge reset) begin
      if (reset)                               busy_q[i] <= 1'b0;
      else if (issue_ok && issue_rd == 5'(i))  busy_q[i] <= 1'b1;
      else if (wr_en && wr_sel == 5'(i))       busy_q[i] <= 1'b0;
    end
  end

  assign busy_vec = {busy_q, 1'b0};
  assign rs1_busy = busy_vec[rs1_sel];
  assign rs2_busy = busy_vec[rs2_sel];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized bench: the driver predicts grants and writes into a queue, and the
// monitor pops them as the write port presents them.
module tb_regfile_wb_arbiter;
  logic        clock = 1'b0;
  logic        reset;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [4:0]  a_rd, b_rd;
  logic [31:0] a_data, b_data;
  logic        wr_en;
  logic [4:0]  wr_sel;
  logic [31:0] wr_data;
  logic        issue_valid, issue_stall;
  logic [4:0]  issue_rd, rs1_sel, rs2_sel;
  logic        rs1_busy, rs2_busy;
  logic [31:0] busy_vec;

  regfile_wb_arbiter dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_stall(issue_stall),
    .rs1_sel(rs1_sel), .rs2_sel(rs2_sel), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .busy_vec(busy_vec)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  // Reference model state
  bit          mdl_busy[32];
  bit          a_turn;
  bit          cur_v;
  logic [4:0]  cur_rd;
  bit          g_v, g_is_b, iss_set;
  logic [4:0]  g_rd, iss_rd;
  logic [31:0] g_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mdl_vec();
    logic [31:0] v;
    v = '0;
    for (int i = 1; i < 32; i++) v[i] = mdl_busy[i];
    return v;
  endfunction

  function automatic logic [4:0] rnd_idx();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction

  // Monitor: every cycle, the write port must show exactly the queued write, or nothing.
  initial begin
    wr_t e;
    forever begin
      @(negedge clock);
      if (mon_en && !reset) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("wr_en", {31'd0, wr_en}, 32'd1);
          if (wr_en) begin
            chk("wr_sel", {27'd0, wr_sel}, {27'd0, e.rd});
            chk("wr_data", wr_data, e.data);
          end
        end else begin
          chk("wr_en_idle", {31'd0, wr_en}, 32'd0);
        end
      end
    end
  end

  initial begin
    bit exp_a, exp_b, exp_stall;
    reset = 1'b1;
    a_valid = 0; b_valid = 0; a_rd = 0; b_rd = 0; a_data = 0; b_data = 0;
    issue_valid = 0; issue_rd = 0; rs1_sel = 0; rs2_sel = 0;
    for (int i = 0; i < 32; i++) mdl_busy[i] = 1'b0;
    a_turn = 1'b1; cur_v = 1'b0; cur_rd = '0;
    g_v = 1'b0; g_is_b = 1'b0; g_rd = '0; g_data = '0; iss_set = 1'b0; iss_rd = '0;

    #12;
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_sel", {27'd0, wr_sel}, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_busy_vec", busy_vec, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    mon_en = 1'b1;

    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clock);
      // Commit this edge: retiring write clears, then accepted issue sets.
      if (cur_v) mdl_busy[cur_rd] = 1'b0;
      if (iss_set) mdl_busy[iss_rd] = 1'b1;
      cur_v  = g_v && (g_rd != 5'd0);
      cur_rd = g_rd;
      if (cur_v) exp_q.push_back('{g_rd, g_data});
      if (g_v) a_turn = g_is_b;

      if (cyc == 400) begin
        #1 reset = 1'b1;
        #1;
        chk("async_rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("async_rst_wr_sel", {27'd0, wr_sel}, 32'd0);
        chk("async_rst_wr_data", wr_data, 32'd0);
        chk("async_rst_busy", busy_vec, 32'd0);
        exp_q.delete();
        for (int i = 0; i < 32; i++) mdl_busy[i] = 1'b0;
        cur_v = 1'b0; a_turn = 1'b1;
        #1 reset = 1'b0;
      end

      #1;
      a_valid = ($urandom_range(0, 9) < 6);
      b_valid = ($urandom_range(0, 9) < 6);
      a_rd = rnd_idx(); b_rd = rnd_idx();
      a_data = $urandom; b_data = $urandom;
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_rd = rnd_idx();
      rs1_sel = rnd_idx(); rs2_sel = rnd_idx();
      if (cyc == 399) begin
        // Guarantee a live write on the port when reset hits.
        a_valid = 1'b1; b_valid = 1'b0; a_rd = 5'd13; a_data = 32'hDEADBEEF;
      end
      if (cyc == 400) begin
        a_valid = 1'b1; b_valid = 1'b1;
      end
      if (cyc == 10) begin
        a_valid = 1'b1; b_valid = 1'b0; a_rd = 5'd0; a_data = 32'h1234;
        issue_valid = 1'b1; issue_rd = 5'd0;
      end

      @(negedge clock);
      exp_a = a_valid && (!b_valid || a_turn);
      exp_b = b_valid && !exp_a;
      exp_stall = issue_valid && (issue_rd != 5'd0) && mdl_busy[issue_rd];
      chk("a_ready", {31'd0, a_ready}, {31'd0, exp_a});
      chk("b_ready", {31'd0, b_ready}, {31'd0, exp_b});
      chk("issue_stall", {31'd0, issue_stall}, {31'd0, exp_stall});
      chk("rs1_busy", {31'd0, rs1_busy}, {31'd0, mdl_busy[rs1_sel] && rs1_sel != 0});
      chk("rs2_busy", {31'd0, rs2_busy}, {31'd0, mdl_busy[rs2_sel] && rs2_sel != 0});
      chk("busy_vec", busy_vec, mdl_vec());
      if (cyc == 400) chk("post_rst_a_wins", {31'd0, a_ready}, 32'd1);

      g_v    = exp_a || exp_b;
      g_is_b = exp_b;
      g_rd   = exp_a ? a_rd : b_rd;
      g_data = exp_a ? a_data : b_data;
      iss_set = issue_valid && (issue_rd != 5'd0) && !mdl_busy[issue_rd];
      iss_rd  = issue_rd;
    end

    @(posedge clock);
    if (cur_v) mdl_busy[cur_rd] = 1'b0;
    if (iss_set) mdl_busy[iss_rd] = 1'b1;
    if (g_v && g_rd != 5'd0) exp_q.push_back('{g_rd, g_data});
    #1;
    a_valid = 0; b_valid = 0; issue_valid = 0;
    @(negedge clock);
    #1;
    chk("queue_drain", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: none; register file fixed at 32 x 32-bit, index 0 hardwired zero.
REQ-002 clock  input  1  sole clock; all state updates on posedge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 a_valid / a_ready  input / output  1 / 1  requester A (ALU writeback) handshake.
REQ-005 a_rd / a_data  input  5 / 32  requester A destination index and value.
REQ-006 b_valid / b_ready  input / output  1 / 1  requester B (load writeback) handshake.
REQ-007 b_rd / b_data  input  5 / 32  requester B destination index and value.
REQ-008 wr_en  output  1  register-file write enable, registered.
REQ-009 wr_sel / wr_data  output  5 / 32  register-file write index and value, registered.
REQ-010 issue_valid / issue_rd  input  1 / 5  decode announces instruction that will write issue_rd.
REQ-011 issue_stall  output  1  combinational; issue refused this cycle (WAW).
REQ-012 rs1_sel / rs2_sel  input  5 / 5  source indices from decode.
REQ-013 rs1_busy / rs2_busy  output  1 / 1  combinational; source has pending write.
REQ-014 busy_vec  output  32  registered pending-write scoreboard, bit i = register i.

Function
REQ-015 Arbiter SHALL grant at most one requester per cycle; transfer occurs on posedge where valid && ready.
REQ-016 a_ready/b_ready SHALL be combinational from valids and last_grant; ready SHALL NOT depend on the other ready.
REQ-017 Only one valid: that requester gets ready=1.
REQ-018 Both valid: round-robin; requester not granted last SHALL win; after reset last_grant=B, so A wins first conflict.
REQ-019 last_grant SHALL update only on a completed transfer.
REQ-020 Transfer at edge N SHALL drive wr_en=1, wr_sel=rd, wr_data=data during cycle N..N+1 (1-cycle latency); file writes at intervening negedge.
REQ-021 No transfer at edge N: wr_en=0 next cycle; wr_sel/wr_data hold previous values.
REQ-022 Transfer with rd=0 SHALL be accepted (ready honoured) but SHALL produce wr_en=0.
REQ-023 Throughput: one write per cycle sustained; back-to-back transfers legal.
REQ-024 issue_stall = issue_valid && issue_rd!=0 && busy_vec[issue_rd].
REQ-025 issue_valid && !issue_stall && issue_rd!=0 SHALL set busy_vec[issue_rd] at posedge.
REQ-026 busy_vec[wr_sel] SHALL clear at the posedge ending a wr_en=1 cycle (edge N+1 for transfer at N).
REQ-027 Set and clear of same index on same edge: set wins.
REQ-028 busy_vec[0] SHALL always read 0.
REQ-029 rsX_busy = busy_vec[rsX_sel]; rsX_sel=0 always 0.
REQ-030 Writeback to index not marked busy SHALL still write the file; clear is a no-op.

Reset
REQ-031 Reset asserted: wr_en=0, wr_sel=0, wr_data=0, busy_vec=0, last_grant=B, regardless of clock.
REQ-032 Reset mid-transfer SHALL abandon the pending write (wr_en=0 immediately); requesters see ready recomputed from cleared state.
REQ-033 Outputs SHALL be valid from first posedge after reset deasserts.

Verification
REQ-034 Single A: a_valid=1, a_rd=5, a_data=0xDEADBEEF at edge N -> a_ready=1; cycle N..N+1 wr_en=1, wr_sel=5, wr_data=0xDEADBEEF; wr_en=0 after.
REQ-035 Contention: both valid 4 cycles, a_rd=1, b_rd=2 -> grants A,B,A,B; wr_sel 1,2,1,2 each one cycle later.
REQ-036 Scoreboard: issue rd=7 at edge 1 -> busy_vec=0x80, rs1_sel=7 gives rs1_busy=1; A writes rd=7 at edge 4 -> busy_vec=0 after edge 5; re-issue rd=7 at edge 3 -> issue_stall=1.
REQ-037 Same-edge set/clear: wr_en=1 wr_sel=9 with issue rd=9 not stalled (bit previously clear) -> busy_vec[9]=1 after edge.
REQ-038 x0: a_rd=0, data 0x1234 -> a_ready=1, wr_en stays 0; issue rd=0 -> busy_vec stays 0, no stall.
REQ-039 Reset async: assert reset between edges while wr_en=1, busy_vec=0xFFFFFFFE -> all outputs 0 without clock edge; next conflict grants A.
